mux_nx1_stream: RTL
===================

MUX_NX1_STREAM -- requirements
Module: mux_nx1_stream

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (N >= 2).
REQ-002 SHALL have parameter W, default 8, data width per channel (W >= 1).
REQ-003 SHALL have derived constant SW = max(1, clog2(N)), the select/grant width.
REQ-004 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port a  input  N*W  flattened channel data; channel i = a[i*W +: W].
REQ-007 SHALL have port a_valid  input  N  per-channel valid.
REQ-008 SHALL have port a_ready  output  N  per-channel ready (combinational).
REQ-009 SHALL have port s  input  SW  fixed-mode select.
REQ-010 SHALL have port mode  input  1  0 = fixed select via s, 1 = round-robin.
REQ-011 SHALL have port y  output  W  registered output data.
REQ-012 SHALL have port y_valid  output  1  output register holds valid data.
REQ-013 SHALL have port y_ready  input  1  downstream accepts y.
REQ-014 SHALL have port grant  output  SW  index of the channel whose data is in y.

Function
REQ-015 SHALL define load = !y_valid || y_ready; capture occurs only when load is 1 and the candidate channel is valid.
REQ-016 SHALL transfer a channel on a cycle where a_valid[i] && a_ready[i]; y, grant and y_valid update on that edge (latency 1 cycle).
REQ-017 Mode 0: the candidate is s; a_ready[s] = load; all other a_ready bits SHALL be 0.
REQ-018 Mode 0: if s >= N (N not a power of 2), there SHALL be no candidate; a_ready all 0 and no capture.
REQ-019 Mode 1: the candidate SHALL be the first valid channel searched from ptr+1 upward, modulo N; a_ready[candidate] = load; all other bits 0; if no channel is valid, a_ready is all 0.
REQ-020 ptr SHALL update to the captured index on every capture in either mode; it is unchanged otherwise.
REQ-021 While y_valid && !y_ready, y and grant SHALL hold, and changes on s, mode, a or a_valid SHALL not affect them.
REQ-022 When y_ready = 1 and no capture occurs, y_valid SHALL clear on that edge; y and grant hold their last values.
REQ-023 When y_ready = 1 and a capture occurs on the same edge, y_valid SHALL remain 1 (back-to-back, one word per cycle).
REQ-024 A mode change SHALL take effect at the next candidate evaluation; there is no flush.
REQ-025 Round-robin wrap: after granting channel N-1, the search SHALL start at channel 0.

Reset
REQ-026 While rst_n = 0: y = 0, y_valid = 0, grant = 0, and ptr = N-1, so channel 0 has first priority.
REQ-027 Reset SHALL apply immediately, including mid-transfer; any held word is discarded.
REQ-028 a_ready SHALL be all 0 while rst_n = 0.

Structure
REQ-029 Package mux_pkg SHALL hold the clog2 function, the SW derivation and the mode encodings MODE_FIXED = 0 and MODE_RR = 1.
REQ-030 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: valid mask and ptr; outputs: found and index), instantiated once.

Verification
REQ-031 Fixed mode, N=4, W=1, y_ready=1, all a_valid=1: (s=00,a=0001), (01,0010), (10,0100), (11,1000), (11,0111), (00,1110) -> y = 1,1,1,1,0,0 one cycle after each, with grant = s.
REQ-032 Round-robin, N=4, all valid, y_ready=1 -> grant sequence 0,1,2,3,0; a_valid=0101 -> grants alternate 0,2.
REQ-033 Backpressure: capture ch1 = 8'hA5, hold y_ready=0 for 3 cycles while s and a change -> y stays A5 with y_valid=1 and a_ready=0; then y_ready=1 -> next word captured on that same edge.
REQ-034 Drain: y_valid=1, y_ready=1, no valid inputs -> y_valid goes to 0 and y holds its last value.
REQ-035 Reset mid-operation: assert rst_n=0 between clock edges while y_valid=1 -> y=0, y_valid=0 and grant=0 immediately; after release in round-robin mode with all inputs valid -> first grant is 0.
REQ-036 N=3, mode 0, s=11 with all valid -> a_ready=000 and y_valid stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the streaming N:1 multiplexer.
// Holds the mode encodings and the select-width derivation.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Select/grant width, never narrower than one bit.
  function automatic int sw_of(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of valid strictly after ptr, modulo N.
// Ports: valid (mask), ptr (last grant) -> found, index.
module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] index
);

  localparam logic [SW-1:0] LAST = SW'(N - 1);

  always_comb begin
    logic [SW-1:0] cur;
    found = 1'b0;
    index = '0;
    cur   = ptr;
    // Walk ptr+1, ptr+2, ... wrapping at N-1; first hit wins.
    for (int k = 0; k < N; k++) begin
      cur = (cur == LAST) ? '0 : cur + 1'b1;
      if (!found && valid[cur]) begin
        found = 1'b1;
        index = cur;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// Streaming N:1 mux with fixed or round-robin selection and a registered output.
// Ports: a/a_valid/a_ready (N inputs), s, mode, y/y_valid/y_ready, grant.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = sw_of(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] a,
  input  logic [N-1:0]   a_valid,
  output logic [N-1:0]   a_ready,
  input  logic [SW-1:0]  s,
  input  logic           mode,
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  grant
);

  localparam logic [SW-1:0] LAST  = SW'(N - 1);
  localparam logic [SW:0]   N_EXT = (SW + 1)'(N);

  mode_e         mode_q;
  logic          load;
  logic          rr_found;
  logic [SW-1:0] rr_index;
  logic          cand_ok;
  logic [SW-1:0] cand_idx;
  logic [W-1:0]  cand_data;
  logic          capture;
  logic [SW-1:0] ptr;

  assign mode_q = mode_e'(mode);
  assign load   = !y_valid || y_ready;

  rr_pick #(
    .N  (N),
    .SW (SW)
  ) u_pick (
    .valid (a_valid),
    .ptr   (ptr),
    .found (rr_found),
    .index (rr_index)
  );

  // Fixed mode with s out of range (N not a power of 2) has no candidate.
  always_comb begin
    cand_ok  = 1'b0;
    cand_idx = s;
    unique case (mode_q)
      MODE_FIXED: begin
        cand_ok  = ({1'b0, s} < N_EXT);
        cand_idx = s;
      end
      MODE_RR: begin
        cand_ok  = rr_found;
        cand_idx = rr_index;
      end
      default: begin
        cand_ok  = 1'b0;
        cand_idx = s;
      end
    endcase
  end

  always_comb begin
    a_ready = '0;
    if (rst_n && load && cand_ok) begin
      a_ready[cand_idx] = 1'b1;
    end
  end

  always_comb begin
    cand_data = '0;
    for (int i = 0; i < N; i++) begin
      if (cand_idx == SW'(i)) begin
        cand_data = a[i*W +: W];
      end
    end
  end

  assign capture = |(a_ready & a_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
      grant   <= '0;
      ptr     <= LAST;
    end else if (capture) begin
      y       <= cand_data;
      y_valid <= 1'b1;
      grant   <= cand_idx;
      ptr     <= cand_idx;
    end else if (y_ready) begin
      y_valid <= 1'b0;
    end
  end

endmodule
